// File: rtl/srl_fifo_pkg.sv
// Shared constants and control-state encoding for the SRL-based FIFO.
package srl_fifo_pkg;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        MORE
    } state_e;

endpackage

// File: rtl/srl16_bank.sv
// WIDTH-wide bank of SRLC16E-style shift registers sharing one clock enable
// and one read address; contents are deliberately left unreset.
module srl16_bank
    import srl_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk_i,
    input  logic              ce_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  d_i,
    output logic [WIDTH-1:0]  q_o
);

    genvar b;
    generate
        for (b = 0; b < WIDTH; b++) begin : g_bit
            logic [DEPTH-1:0] sr_q;

            always_ff @(posedge clk_i) begin
                if (ce_i) begin
                    sr_q <= {sr_q[DEPTH-2:0], d_i[b]};
                end
            end

            assign q_o[b] = sr_q[addr_i];
        end
    endgenerate

endmodule

// File: rtl/srl_fifo.sv
// 17-entry FIFO: 16-deep SRL shift storage feeding a registered output stage,
// with a one-cycle bypass straight into the output register when storage is empty.
module srl_fifo
    import srl_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] WR_DATA,
    output logic             FULL,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic [CNT_W-1:0] LEVEL
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               valid;
    logic               push, pop, load, shift_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [WIDTH-1:0]   srl_rd;

    assign valid   = (state_q != IDLE);
    assign FULL    = (cnt_q == CNT_W'(DEPTH));
    assign push    = WR_EN & ~FULL & ~RST;
    assign pop     = valid & DOUT_READY & ~RST;
    assign load    = ~valid | pop;
    assign rd_addr = cnt_q[ADDR_W-1:0] - ADDR_W'(1);

    srl16_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk_i  (CLK),
        .ce_i   (shift_en),
        .addr_i (rd_addr),
        .d_i    (WR_DATA),
        .q_o    (srl_rd)
    );

    // Read uses the pre-shift address, so a simultaneous push cannot disturb the word being loaded.
    always_comb begin
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        shift_en = 1'b0;
        if (load) begin
            if (cnt_q != '0) begin
                dout_d   = srl_rd;
                shift_en = push;
                if (!push) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (push) begin
                dout_d = WR_DATA;
            end
        end else if (push) begin
            shift_en = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (push) state_d = HEAD;
            HEAD: begin
                if (pop && !push)      state_d = IDLE;
                else if (push && !pop) state_d = MORE;
            end
            MORE: if (cnt_d == '0) state_d = HEAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign DOUT       = dout_q;
    assign DOUT_VALID = valid;
    assign LEVEL      = cnt_q + CNT_W'(valid);

endmodule
